// File: rtl/uart_rx_oversample.sv
// 16x oversampling UART receiver (8N1) with a single-byte holding register.
// Bits are resolved by 3-sample majority vote at ticks 7/8/9 of each bit period.
module uart_rx_oversample #(
  parameter int OS_DIV = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int DW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(OS_DIV - 1);

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [3:0]      tick_idx_q, tick_idx_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            s7_q, s7_d, s8_q, s8_d;
  logic            rx_meta_q, rx_meta_d, rx_s_q, rx_s_d, rx_prev_q, rx_prev_d;
  logic [1:0]      settle_q, settle_d;
  logic            armed_q, armed_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  logic            tick, maj, deliver, rd_accept;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      tick_idx_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      settle_q    <= '0;
      armed_q     <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      tick_idx_q  <= tick_idx_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      s7_q        <= s7_d;
      s8_q        <= s8_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      rx_prev_q   <= rx_prev_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    tick_idx_d  = tick_idx_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    s7_d        = s7_q;
    s8_d        = s8_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    deliver     = 1'b0;

    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    rx_prev_d = rx_s_q;
    // rx_s only reflects the real line once the synchronizer has flushed its
    // reset value; arm start detection only after a genuine high is seen there.
    settle_d  = {settle_q[0], 1'b1};
    armed_d   = armed_q | (settle_q[1] & rx_s_q);

    tick = (div_q == DIV_LAST);
    maj  = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);

    if (state_q == IDLE) begin
      div_d      = '0;
      tick_idx_d = '0;
      bit_cnt_d  = '0;
      if (armed_q && rx_prev_q && !rx_s_q) begin
        state_d = START;
      end
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        tick_idx_d = tick_idx_q + 1'b1;
        if (tick_idx_q == 4'd7) s7_d = rx_s_q;
        if (tick_idx_q == 4'd8) s8_d = rx_s_q;
      end
      case (state_q)
        START: begin
          if (tick && tick_idx_q == 4'd9 && maj) begin
            state_d    = IDLE;
            div_d      = '0;
            tick_idx_d = '0;
          end else if (tick && tick_idx_q == 4'd15) begin
            state_d = DATA;
          end
        end
        DATA: begin
          if (tick && tick_idx_q == 4'd9) begin
            shreg_d = {maj, shreg_q[7:1]};
          end
          if (tick && tick_idx_q == 4'd15) begin
            if (bit_cnt_q == 3'd7) begin
              state_d   = STOP;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick && tick_idx_q == 4'd9) begin
            deliver     = maj;
            frame_err_d = ~maj;
            state_d     = IDLE;
            div_d       = '0;
            tick_idx_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    rd_accept = rd_en & valid_q;
    if (deliver) begin
      if (!valid_q || rd_accept) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
        if (rd_accept) overrun_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rd_accept) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 SHALL have parameter OS_DIV, default 27, meaning clk cycles per 16x oversample tick (50 MHz / 115200 baud / 16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port rd_en  input  1  consumer acknowledge of the held byte.
REQ-006 SHALL have port data_out  output  8  last accepted byte.
REQ-007 SHALL have port valid  output  1  data_out holds an unread byte.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-009 SHALL have port overrun  output  1  sticky flag: a byte was lost.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-012 SHALL keep a divider counter 0..OS_DIV-1 that issues one tick per OS_DIV clocks, plus a 4-bit tick index 0..15 per bit period.
REQ-013 SHALL implement states IDLE, START, DATA, STOP.
REQ-014 IDLE: on rx_s high-to-low transition SHALL enter START with the divider and tick index cleared; the divider is held at 0 while in IDLE.
REQ-015 Each bit value SHALL be the majority of rx_s taken at ticks 7, 8 and 9, resolved at tick 9.
REQ-016 START: at tick 9, a majority of 1 SHALL return to IDLE (false start, no flags); a majority of 0 SHALL enter DATA at the next tick 0.
REQ-017 DATA: SHALL capture 8 bits LSB first, one per 16 ticks, with a 3-bit bit counter; after bit 7 it SHALL enter STOP.
REQ-018 STOP: at tick 9, a majority of 1 SHALL deliver the byte to the holding register; a majority of 0 SHALL pulse frame_err for one clock, discard the byte, and leave valid, data_out and overrun unchanged.
REQ-019 After the STOP decision the FSM SHALL return to IDLE in the same cycle, so a new start edge is accepted from the next clock.
REQ-020 Delivery SHALL set valid and load data_out one clock after the tick-9 STOP decision cycle.
REQ-021 rd_en with valid=1 SHALL clear valid on the next clock; rd_en with valid=0 SHALL be ignored.
REQ-022 A delivery while valid=1 without rd_en in the same cycle SHALL set overrun and keep the old data_out.
REQ-023 A delivery coinciding with rd_en while valid=1 SHALL load the new byte, keep valid=1, and not set overrun.
REQ-024 overrun SHALL clear only on an rd_en accepted while valid=1, or on reset.
REQ-025 data_out SHALL be stable whenever valid=1 except at an accepted delivery per REQ-023.
REQ-026 The bit period SHALL be exactly 16*OS_DIV clocks; there is no drift compensation.

Reset
REQ-027 With rst=0 at a clk edge, SHALL force state=IDLE, counters=0, synchronizer flops=1, data_out=8'h00, valid=0, frame_err=0, overrun=0, busy=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; no byte and no flag SHALL be produced from it after release.
REQ-029 After release, the receiver SHALL ignore rx until it has seen rx_s high, so a line held low across reset is not taken as a start bit.

Verification (OS_DIV=4, bit period 64 clocks)
REQ-030 Frame 0xA5 with a good stop bit -> valid=1, data_out=8'hA5 exactly 1 clock after the stop-bit tick 9; frame_err=0, overrun=0.
REQ-031 Low glitch of 20 clocks on an idle line -> busy returns low after the start-bit tick 9; valid, frame_err and overrun stay 0.
REQ-032 Frame 0x3C with the stop bit low -> frame_err one-cycle pulse; valid stays 0; the FSM accepts a following 0x81 frame normally.
REQ-033 Frames 0x11 then 0x22 with no rd_en -> valid=1, data_out=8'h11, overrun=1; one rd_en pulse -> valid=0 and overrun=0 next clock.
REQ-034 Frames 0x11 then 0x22 with rd_en asserted exactly in the delivery cycle of 0x22 -> data_out=8'h22, valid=1, overrun=0.
REQ-035 rst=0 asserted at bit 4 of frame 0xFF with rx held low through release -> all outputs at reset values, then no delivery until rx idles high and a full new frame 0x55 arrives, which yields data_out=8'h55.
